// File: rtl/accum_pkg.sv
// accum_pkg: shared FSM state type, channel-index width helper and clamping/wrapping adder.
package accum_pkg;
  typedef enum logic {IDLE, RUN} acc_state_t;
  function automatic int ch_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Inputs arrive sign-extended to 64 bits; result is clamped or wrapped into a w-bit signed range.
  function automatic logic signed [63:0] sat_add(logic signed [63:0] a, logic signed [63:0] b, int w, bit sat);
    logic signed [63:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return sat ? (s > hi ? hi : s < lo ? lo : s) : (s <<< (64 - w)) >>> (64 - w);
  endfunction
endpackage

// File: rtl/complex_accumulator_mc_if.sv
// complex_accumulator_mc_if: config, sample input and sum output bus of the accumulator.
interface complex_accumulator_mc_if #(
  parameter int CHANNELS     = 4,
  parameter int DATA_W       = 16,
  parameter int MAX_LEN_BITS = 9,
  parameter int ACC_W        = 25
);
  localparam int CH_W = accum_pkg::ch_w(CHANNELS);
  logic                     config_valid;
  logic [MAX_LEN_BITS-1:0]  config_length;
  logic                     busy;
  logic                     in_valid;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_re, in_im;
  logic                     flush;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [ACC_W-1:0]  out_re, out_im;
  logic                     done;
  logic                     overrun;
  modport master (
    output config_valid, config_length, in_valid, in_ch, in_re, in_im, flush,
    input  busy, out_valid, out_ch, out_re, out_im, done, overrun
  );
  modport slave (
    input  config_valid, config_length, in_valid, in_ch, in_re, in_im, flush,
    output busy, out_valid, out_ch, out_re, out_im, done, overrun
  );
endinterface

// File: rtl/complex_sat_add.sv
// complex_sat_add: combinational complex accumulate step with optional saturation.
module complex_sat_add import accum_pkg::*; #(
  parameter int IN_W     = 16,
  parameter int ACC_W    = 25,
  parameter int SATURATE = 0
) (
  input  logic signed [ACC_W-1:0] acc_re,
  input  logic signed [ACC_W-1:0] acc_im,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic signed [ACC_W-1:0] sum_re,
  output logic signed [ACC_W-1:0] sum_im
);
  assign sum_re = ACC_W'(sat_add(64'(acc_re), 64'(in_re), ACC_W, SATURATE != 0));
  assign sum_im = ACC_W'(sat_add(64'(acc_im), 64'(in_im), ACC_W, SATURATE != 0));
endmodule

// File: rtl/complex_accumulator_mc.sv
// complex_accumulator_mc: per-channel complex sums over interleaved samples, one registered sum per channel per frame.
module complex_accumulator_mc import accum_pkg::*; #(
  parameter int CHANNELS     = 4,
  parameter int DATA_W       = 16,
  parameter int MAX_LEN_BITS = 9,
  parameter int ACC_W        = 25,
  parameter int SATURATE     = 0
) (
  input logic clk,
  input logic reset,
  complex_accumulator_mc_if.slave bus
);
  localparam int CH_W = ch_w(CHANNELS);
  acc_state_t state_q, state_d;
  logic [MAX_LEN_BITS-1:0] len_q;
  logic [MAX_LEN_BITS-1:0] cnt_q [CHANNELS];
  logic signed [ACC_W-1:0] acc_re_q [CHANNELS];
  logic signed [ACC_W-1:0] acc_im_q [CHANNELS];
  logic signed [ACC_W-1:0] sum_re, sum_im, out_re_q, out_im_q;
  logic [CHANNELS-1:0] chan_done_q, ch_bit;
  logic [CH_W-1:0] ch_idx, out_ch_q;
  logic run, start, ch_ok, accept, last, final_ch, emit;
  logic out_valid_q, done_q, overrun_q;
  assign run      = state_q == RUN;
  assign ch_ok    = {1'b0, bus.in_ch} < (CH_W + 1)'(CHANNELS);
  assign ch_idx   = ch_ok ? bus.in_ch : '0;
  assign start    = !run && bus.config_valid && bus.config_length != '0;
  assign accept   = bus.in_valid && run && ch_ok && !chan_done_q[ch_idx];
  assign last     = accept && cnt_q[ch_idx] == len_q - 1'b1;
  assign final_ch = last && &(chan_done_q | ch_bit);
  assign emit     = last && !bus.flush;
  always_comb begin
    ch_bit = '0;
    ch_bit[ch_idx] = 1'b1;
  end
  complex_sat_add #(.IN_W(DATA_W), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_add (
    .acc_re(acc_re_q[ch_idx]),
    .acc_im(acc_im_q[ch_idx]),
    .in_re (bus.in_re),
    .in_im (bus.in_im),
    .sum_re(sum_re),
    .sum_im(sum_im)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = run ? (bus.flush || final_ch ? IDLE : RUN) : (start ? RUN : IDLE);
  end
  always_comb begin
    bus.busy      = run;
    bus.out_valid = out_valid_q;
    bus.out_ch    = out_ch_q;
    bus.out_re    = out_re_q;
    bus.out_im    = out_im_q;
    bus.done      = done_q;
    bus.overrun   = overrun_q;
  end
  // A flush in the same cycle as a completion suppresses that channel's output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_re_q[c] <= '0;
        acc_im_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      chan_done_q <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= emit;
      done_q      <= final_ch && !bus.flush;
      overrun_q   <= (bus.in_valid && !accept) || (!start && overrun_q);
      if (emit) begin
        out_ch_q <= ch_idx;
        out_re_q <= sum_re;
        out_im_q <= sum_im;
      end
      if (start) len_q <= bus.config_length;
      if (start || (run && bus.flush)) begin
        for (int c = 0; c < CHANNELS; c++) begin
          acc_re_q[c] <= '0;
          acc_im_q[c] <= '0;
          cnt_q[c]    <= '0;
        end
        chan_done_q <= '0;
      end else if (accept) begin
        acc_re_q[ch_idx]    <= last ? '0 : sum_re;
        acc_im_q[ch_idx]    <= last ? '0 : sum_im;
        cnt_q[ch_idx]       <= last ? '0 : cnt_q[ch_idx] + 1'b1;
        chan_done_q[ch_idx] <= last;
      end
    end
  end
endmodule

// File: tb/tb_complex_accumulator_mc.sv
// tb_complex_accumulator_mc: directed frames with a model-fed scoreboard plus saturate/wrap side instances.
module tb_complex_accumulator_mc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  complex_accumulator_mc_if #(.CHANNELS(4), .DATA_W(16), .MAX_LEN_BITS(9), .ACC_W(25)) bus();
  complex_accumulator_mc_if #(.CHANNELS(4), .DATA_W(16), .MAX_LEN_BITS(9), .ACC_W(16)) sbus();
  complex_accumulator_mc_if #(.CHANNELS(4), .DATA_W(16), .MAX_LEN_BITS(9), .ACC_W(16)) wbus();
  complex_accumulator_mc #(.CHANNELS(4), .DATA_W(16), .MAX_LEN_BITS(9), .ACC_W(25), .SATURATE(0))
    dut (.clk(clk), .reset(reset), .bus(bus));
  complex_accumulator_mc #(.CHANNELS(4), .DATA_W(16), .MAX_LEN_BITS(9), .ACC_W(16), .SATURATE(1))
    dut_sat (.clk(clk), .reset(reset), .bus(sbus));
  complex_accumulator_mc #(.CHANNELS(4), .DATA_W(16), .MAX_LEN_BITS(9), .ACC_W(16), .SATURATE(0))
    dut_wrap (.clk(clk), .reset(reset), .bus(wbus));

  typedef struct {int ch; int re; int im; bit fin;} exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int mre[4], mim[4], mcnt[4], mlen;
  bit mdone[4];
  bit mrun, mover;

  task automatic check(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mre[i] = 0; mim[i] = 0; mcnt[i] = 0; mdone[i] = 0;
    end
  endtask

  task automatic cfg(int len);
    if (!mrun && len != 0) begin
      mrun = 1; mlen = len; mover = 0;
      model_clear();
    end
    bus.config_valid = 1'b1;
    bus.config_length = 9'(len);
    @(posedge clk); #1;
    bus.config_valid = 1'b0;
  endtask

  task automatic send(int ch, int re, int im);
    bit fin;
    if (mrun && !mdone[ch]) begin
      mre[ch] += re; mim[ch] += im; mcnt[ch]++;
      if (mcnt[ch] == mlen) begin
        mdone[ch] = 1;
        fin = mdone[0] && mdone[1] && mdone[2] && mdone[3];
        q.push_back('{ch, mre[ch], mim[ch], fin});
        mre[ch] = 0; mim[ch] = 0; mcnt[ch] = 0;
        if (fin) mrun = 0;
      end
    end else mover = 1;
    bus.in_valid = 1'b1;
    bus.in_ch = 2'(ch);
    bus.in_re = 16'(re);
    bus.in_im = 16'(im);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic flush_frame();
    mrun = 0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic status(string tag);
    check({tag, "_busy"}, bus.busy, mrun);
    check({tag, "_overrun"}, bus.overrun, mover);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) check("spurious_out_valid", bus.out_valid, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("out_ch", bus.out_ch, e.ch);
        check("out_re", bus.out_re, e.re);
        check("out_im", bus.out_im, e.im);
        check("done", bus.done, e.fin);
      end
    end
  end

  initial begin
    {bus.config_valid, bus.in_valid, bus.flush, bus.in_ch, bus.in_re, bus.in_im} = '0;
    bus.config_length = '0;
    {sbus.config_valid, sbus.in_valid, sbus.flush, sbus.in_ch, sbus.in_re, sbus.in_im} = '0;
    sbus.config_length = '0;
    {wbus.config_valid, wbus.in_valid, wbus.flush, wbus.in_ch, wbus.in_re, wbus.in_im} = '0;
    wbus.config_length = '0;
    mrun = 0; mover = 0; mlen = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_out_re", bus.out_re, 0);
    check("rst_out_im", bus.out_im, 0);
    check("rst_done", bus.done, 0);
    status("rst");
    // Saturating vs wrapping 16-bit accumulators fed four maximal samples.
    {sbus.config_valid, wbus.config_valid} = 2'b11;
    sbus.config_length = 9'd4; wbus.config_length = 9'd4;
    @(posedge clk); #1;
    {sbus.config_valid, wbus.config_valid} = 2'b00;
    for (int i = 0; i < 4; i++) begin
      {sbus.in_valid, wbus.in_valid} = 2'b11;
      sbus.in_re = 16'sd32767; wbus.in_re = 16'sd32767;
      @(posedge clk); #1;
      {sbus.in_valid, wbus.in_valid} = 2'b00;
    end
    check("sat_out_valid", sbus.out_valid, 1);
    check("sat_out_re", sbus.out_re, 32767);
    check("sat_out_im", sbus.out_im, 0);
    check("wrap_out_valid", wbus.out_valid, 1);
    check("wrap_out_re", wbus.out_re, -4);
    check("wrap_done", wbus.done, 0);
    // Round robin, length 3.
    cfg(3);
    status("t1_cfg");
    for (int i = 1; i <= 12; i++) send((i - 1) % 4, i, 0);
    status("t1_end");
    // Length 1.
    cfg(1);
    send(2, -7, 3);
    status("t2_mid");
    send(0, 100, -100);
    send(3, -32768, 32767);
    send(1, 1, 2);
    status("t2_end");
    // Drops in IDLE and on a completed channel.
    send(1, 5, 5);
    status("t5_idle");
    cfg(2);
    status("t5_cfg");
    send(1, 1, 1);
    send(1, 2, 2);
    send(1, 9, 9);
    status("t5_drop");
    send(0, 4, -4);
    send(0, 4, -4);
    send(2, 100, 0);
    flush_frame();
    status("t5_flush");
    // Flush with partials, then a fresh frame.
    cfg(3);
    send(0, 10, 1);
    send(1, 20, 2);
    flush_frame();
    status("t4_flush");
    cfg(2);
    for (int i = 0; i < 8; i++) send(i % 4, i + 1, -(i + 1));
    status("t4_end");
    // Reset mid-frame, then back-to-back frames.
    cfg(2);
    send(0, 3, 3);
    send(1, 4, 4);
    reset = 1'b1;
    mrun = 0; mover = 0;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_out_re", bus.out_re, 0);
    check("t6_out_im", bus.out_im, 0);
    check("t6_out_ch", bus.out_ch, 0);
    status("t6_rst");
    cfg(2);
    for (int i = 0; i < 8; i++) send(i % 4, 10 * i, i);
    cfg(1);
    status("t6_b2b");
    for (int i = 0; i < 4; i++) send(3 - i, -i, 50 + i);
    status("t6_end");
    repeat (2) @(posedge clk);
    #1 check("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
